// File: rtl/arb_mux_rr.sv
// Round-robin / fixed-priority arbiter over FIFO_UNITS show-ahead FIFOs.
// Generates the one-hot pop and registers the popped word with a valid strobe.
module arb_mux_rr #(
    parameter int unsigned FIFO_UNITS = 4,
    parameter int unsigned WORD_SIZE  = 10,
    parameter int unsigned PTR_L      = 2,
    parameter int unsigned BURST_LEN  = 2,
    parameter int unsigned MODE       = 0
) (
    input  logic                            clk,
    input  logic                            reset_L,
    input  logic [FIFO_UNITS-1:0]           fifo_empty,
    input  logic [FIFO_UNITS*WORD_SIZE-1:0] fifo_data_in,
    input  logic                            dest_almost_full,
    output logic [FIFO_UNITS-1:0]           arb_pop,
    output logic [WORD_SIZE-1:0]            data_out,
    output logic                            valid_out,
    output logic [PTR_L-1:0]                active_ch
);

    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t               state_q;
    logic [PTR_L-1:0]     cur_ch_q, cur_ch_d;
    logic [BW-1:0]        burst_q, burst_d;
    logic [WORD_SIZE-1:0] data_q, sel_data;
    logic                 valid_q;
    logic                 grant;
    logic [FIFO_UNITS-1:0] pop;
    int unsigned          scan_idx;
    logic [PTR_L-1:0]     scan_ch;

    always_comb begin
        pop      = '0;
        grant    = 1'b0;
        cur_ch_d = cur_ch_q;
        burst_d  = burst_q;
        sel_data = '0;
        scan_idx = 0;
        scan_ch  = '0;
        if (reset_L && !dest_almost_full) begin
            if (MODE == 1) begin
                for (int unsigned i = 0; i < FIFO_UNITS; i++) begin
                    scan_ch = PTR_L'(i);
                    if (!grant && !fifo_empty[scan_ch]) begin
                        grant    = 1'b1;
                        cur_ch_d = scan_ch;
                        burst_d  = BW'(1);
                    end
                end
            end else if (state_q == SERVE && !fifo_empty[cur_ch_q] && burst_q < BURST_MAX) begin
                grant   = 1'b1;
                burst_d = burst_q + BW'(1);
            end else begin
                // Scan starts after the owner and ends on it, so a lone owner is re-granted without a bubble.
                for (int unsigned k = 1; k <= FIFO_UNITS; k++) begin
                    scan_idx = 32'(cur_ch_q) + k;
                    if (scan_idx >= FIFO_UNITS) scan_idx = scan_idx - FIFO_UNITS;
                    scan_ch = PTR_L'(scan_idx);
                    if (!grant && !fifo_empty[scan_ch]) begin
                        grant    = 1'b1;
                        cur_ch_d = scan_ch;
                        burst_d  = BW'(1);
                    end
                end
            end
        end
        if (grant) begin
            pop[cur_ch_d] = 1'b1;
            sel_data      = fifo_data_in[32'(cur_ch_d)*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q  <= IDLE;
            cur_ch_q <= PTR_L'(FIFO_UNITS - 1);
            burst_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else if (dest_almost_full) begin
            valid_q <= 1'b0;
        end else if (grant) begin
            state_q  <= SERVE;
            cur_ch_q <= cur_ch_d;
            burst_q  <= burst_d;
            data_q   <= sel_data;
            valid_q  <= 1'b1;
        end else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end
    end

    assign arb_pop   = pop;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active_ch = cur_ch_q;

endmodule

// File: tb/tb_arb_mux_rr.sv
// Scoreboard bench for arb_mux_rr: directed pop sequences with a FIFO occupancy model;
// a negedge monitor pops expected words whenever valid_out is seen.
module tb_arb_mux_rr;

    localparam int N = 4;
    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset_L = 1'b0;
    logic         dest_af = 1'b0;
    logic [N-1:0] fifo_empty = '1;
    logic [N*W-1:0] fifo_data = '0;

    logic [N-1:0] pop0, pop1;
    logic [W-1:0] dout0, dout1;
    logic         v0, v1;
    logic [1:0]   ach0, ach1;

    arb_mux_rr #(.FIFO_UNITS(N), .WORD_SIZE(W), .PTR_L(2), .BURST_LEN(2), .MODE(0)) dut_rr (
        .clk(clk), .reset_L(reset_L), .fifo_empty(fifo_empty), .fifo_data_in(fifo_data),
        .dest_almost_full(dest_af), .arb_pop(pop0), .data_out(dout0), .valid_out(v0),
        .active_ch(ach0)
    );

    arb_mux_rr #(.FIFO_UNITS(N), .WORD_SIZE(W), .PTR_L(2), .BURST_LEN(2), .MODE(1)) dut_fp (
        .clk(clk), .reset_L(reset_L), .fifo_empty(fifo_empty), .fifo_data_in(fifo_data),
        .dest_almost_full(dest_af), .arb_pop(pop1), .data_out(dout1), .valid_out(v1),
        .active_ch(ach1)
    );

    always #5 clk = ~clk;

    int           cnt [N];
    logic [W-1:0] head [N];
    logic [W-1:0] exp_q [$];
    int           errors = 0;
    int           checks = 0;
    logic         sel_fp = 1'b0;
    logic         exp_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] cur_pop();
        return sel_fp ? pop1 : pop0;
    endfunction

    function automatic logic cur_valid();
        return sel_fp ? v1 : v0;
    endfunction

    task automatic set_cnt(input int c0, input int c1, input int c2, input int c3);
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    endtask

    // One cycle: drive FIFO view, check pop and valid, push expected word, retire pops.
    task automatic step(input logic [N-1:0] exp_pop, input string name);
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (cnt[i] == 0);
            fifo_data[i*W +: W] = head[i];
        end
        #2;
        p = cur_pop();
        chk({name, " arb_pop"}, 32'(p), 32'(exp_pop));
        chk({name, " valid_out"}, 32'(cur_valid()), 32'(exp_valid));
        for (int i = 0; i < N; i++) begin
            if (exp_pop[i]) exp_q.push_back(head[i]);
            if (p[i] && cnt[i] > 0) cnt[i]--;
        end
        exp_valid = (exp_pop != '0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic         v;
        logic [W-1:0] d;
        v = sel_fp ? v1 : v0;
        d = sel_fp ? dout1 : dout0;
        if (v === 1'b1) begin
            chk("valid has pending expectation", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("data_out", 32'(d), 32'(exp_q.pop_front()));
        end
    end

    logic [N-1:0] seq_rr [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                 4'b0100, 4'b1000, 4'b1000, 4'b0001};

    initial begin
        head[0] = 10'h010; head[1] = 10'h021; head[2] = 10'h032; head[3] = 10'h043;
        set_cnt(1000, 1000, 1000, 1000);
        reset_L = 1'b0;
        @(posedge clk);
        #1;

        step(4'b0000, "reset0");
        step(4'b0000, "reset1");
        chk("reset data_out", 32'(dout0), 32'd0);
        chk("reset active_ch", 32'(ach0), 32'd3);

        reset_L = 1'b1;
        for (int i = 0; i < 9; i++) step(seq_rr[i], "rr burst");

        set_cnt(0, 0, 1000, 0);
        for (int i = 0; i < 5; i++) step(4'b0100, "sparse ch2");
        chk("sparse active_ch", 32'(ach0), 32'd2);

        set_cnt(0, 0, 0, 1000);
        step(4'b1000, "owner setup");
        step(4'b1000, "owner setup b2");
        cnt[0] = 1;
        step(4'b0001, "owner ch0");
        step(4'b1000, "owner empties");
        step(4'b1000, "ch3 b2");
        step(4'b1000, "ch3 regrant");

        set_cnt(1000, 1000, 1000, 1000);
        step(4'b1000, "bp pre ch3");
        step(4'b0001, "bp pre ch0");
        step(4'b0001, "bp pre ch0 b2");
        step(4'b0010, "bp ch1 b1");
        dest_af = 1'b1;
        for (int i = 0; i < 3; i++) step(4'b0000, "bp hold");
        dest_af = 1'b0;
        step(4'b0010, "bp resume ch1");
        step(4'b0100, "bp next ch2");

        reset_L = 1'b0;
        step(4'b0000, "rr reset mid");
        step(4'b0000, "rr reset hold");
        chk("rr reset data_out", 32'(dout0), 32'd0);

        sel_fp = 1'b1;
        set_cnt(0, 2, 0, 1000);
        reset_L = 1'b1;
        step(4'b0010, "fp ch1");
        step(4'b0010, "fp ch1 last");
        chk("fp active_ch", 32'(ach1), 32'd1);
        step(4'b1000, "fp ch3");
        step(4'b1000, "fp ch3 again");
        reset_L = 1'b0;
        step(4'b0000, "fp reset mid");
        step(4'b0000, "fp reset hold");
        chk("fp reset data_out", 32'(dout1), 32'd0);
        chk("fp reset active_ch", 32'(ach1), 32'd3);
        reset_L = 1'b1;
        step(4'b1000, "fp after reset");
        set_cnt(0, 0, 0, 0);
        step(4'b0000, "all empty");
        step(4'b0000, "idle");

        @(negedge clk);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
